// File: rtl/mem_io_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder_pkg
// Description : Shared constants, I/O register enumeration and address decode
//               helper for the CPU memory/I-O responder.
//               No ports (package).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_io_responder_pkg;

   localparam int BYTE_W   = 8;
   localparam int ADDR_W   = 32;
   localparam int DECODE_W = 18;

   localparam logic [1:0]          IO_SEL      = 2'b11;
   localparam logic [DECODE_W-1:0] IO_IN_ADDR  = 18'h30000;
   localparam logic [DECODE_W-1:0] IO_CLK_ADDR = 18'h30004;

   typedef enum logic [2:0] {
      IO_REG_IN   = 3'd0,   // UART RX read / TX write
      IO_REG_CLK0 = 3'd1,   // counter byte 0 + snapshot, program-stop write
      IO_REG_CLK1 = 3'd2,
      IO_REG_CLK2 = 3'd3,
      IO_REG_CLK3 = 3'd4,
      IO_REG_NONE = 3'd5
   } io_reg_e;

   // Maps an I/O window address to the register it selects.
   function automatic io_reg_e io_decode(input logic [DECODE_W-1:0] a);
      io_reg_e r;
      r = IO_REG_NONE;
      case (a)
         IO_IN_ADDR:            r = IO_REG_IN;
         IO_CLK_ADDR:           r = IO_REG_CLK0;
         IO_CLK_ADDR + 18'd1:   r = IO_REG_CLK1;
         IO_CLK_ADDR + 18'd2:   r = IO_REG_CLK2;
         IO_CLK_ADDR + 18'd3:   r = IO_REG_CLK3;
         default:               r = IO_REG_NONE;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_io_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder_if
// Description : CPU byte bus plus UART byte streams and status flags.
//               master : CPU / environment side (drives address, data, UART in)
//               slave  : responder side (drives read data, UART out, flags)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_io_responder_if;
   import mem_io_responder_pkg::*;

   logic [ADDR_W-1:0] mem_a;
   logic [BYTE_W-1:0] mem_dout;
   logic              mem_wr;
   logic [BYTE_W-1:0] mem_din;
   logic              io_buffer_full;
   logic [BYTE_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [BYTE_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              program_stop;
   logic              tx_overflow;

   modport master (
      output mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
      input  mem_din, io_buffer_full, tx_data, tx_valid, rx_ready,
             program_stop, tx_overflow
   );

   modport slave (
      input  mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
      output mem_din, io_buffer_full, tx_data, tx_valid, rx_ready,
             program_stop, tx_overflow
   );

endinterface
`default_nettype wire

// File: rtl/mem_io_responder_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder_sync_fifo
// Description : Single-clock FIFO for the UART TX byte path.
//               push_i/din_i  : write request and data
//               pop_i         : read request (ignored when empty)
//               dout_o        : head entry, 0 when empty
//               full_o/empty_o/count_o : occupancy
//               almost_full_o : registered (count >= DEPTH-2)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_responder_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       din_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       dout_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   almost_full_o
);

   localparam int              c_PW       = $clog2(DEPTH);
   localparam int              c_CW       = c_PW + 1;
   localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(DEPTH);
   localparam logic [c_CW-1:0] c_AF_LEVEL = c_CW'(DEPTH - 2);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [c_PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [c_PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [c_CW-1:0]  count_q, count_d;
   logic             almost_full_q;
   logic             w_empty, w_full, w_push, w_pop;

   assign w_empty = (count_q == '0);
   assign w_full  = (count_q == c_DEPTH);
   assign w_pop   = pop_i && !w_empty;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign w_push  = push_i && (!w_full || w_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         almost_full_q <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         almost_full_q <= (count_d >= c_AF_LEVEL);
      end
   end

   // Storage is not reset; stale entries are masked by the empty flag.
   always_ff @(posedge clk_in) begin
      if (w_push) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o        = w_empty ? '0 : mem_q[rd_ptr_q];
   assign full_o        = w_full;
   assign empty_o       = w_empty;
   assign count_o       = count_q;
   assign almost_full_o = almost_full_q;

endmodule
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder
// Description : Target side of the CPU byte bus: 128 KB RAM plus an I/O
//               window at mem_a[17:16]==2'b11 (UART RX/TX, cycle counter,
//               program stop).
//               clk_in, rst_in : clock, synchronous active-high reset
//               bus (slave)    : CPU request/read data, UART TX/RX streams,
//                                io_buffer_full, program_stop, tx_overflow
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_responder
   import mem_io_responder_pkg::*;
#(
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int TX_FIFO_DEPTH  = 16
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   mem_io_responder_if.slave    bus
);

   logic [BYTE_W-1:0]          ram_q [2**RAM_ADDR_WIDTH];
   logic [BYTE_W-1:0]          ram_rdata_q;
   logic [BYTE_W-1:0]          io_rdata_q, io_rdata_d;
   logic                       src_ram_q, src_ram_d;
   logic [31:0]                cnt_q;
   logic [31:0]                snap_q, snap_d;
   logic                       program_stop_q;
   logic                       tx_overflow_q;

   logic [DECODE_W-1:0]        w_addr;
   logic [ADDR_W-DECODE_W-1:0] w_unused_addr_hi;
   logic [RAM_ADDR_WIDTH-1:0]  w_ram_addr;
   logic                       w_io, w_ram_wr, w_ram_rd, w_io_rd, w_io_wr;
   io_reg_e                    w_reg;
   logic                       w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
   logic                       w_overflow;
   logic [BYTE_W-1:0]          w_tx_din;
   logic [$clog2(TX_FIFO_DEPTH):0] w_unused_tx_count;

   assign w_addr           = bus.mem_a[DECODE_W-1:0];
   assign w_unused_addr_hi = bus.mem_a[ADDR_W-1:DECODE_W];
   assign w_ram_addr       = bus.mem_a[RAM_ADDR_WIDTH-1:0];
   assign w_io             = (w_addr[DECODE_W-1:DECODE_W-2] == IO_SEL);
   assign w_reg            = io_decode(w_addr);
   assign w_ram_wr         =  bus.mem_wr && !w_io;
   assign w_ram_rd         = !bus.mem_wr && !w_io;
   assign w_io_wr          =  bus.mem_wr &&  w_io;
   assign w_io_rd          = !bus.mem_wr &&  w_io;

   // A zero byte written to the TX register is a no-op; the program-stop
   // write pushes a 0x00 terminator instead of the written data.
   assign w_tx_push  = w_io_wr && ((w_reg == IO_REG_IN && bus.mem_dout != '0) ||
                                   (w_reg == IO_REG_CLK0));
   assign w_tx_din   = (w_reg == IO_REG_CLK0) ? '0 : bus.mem_dout;
   assign w_tx_pop   = !w_tx_empty && bus.tx_ready;
   assign w_overflow = w_tx_push && w_tx_full && !w_tx_pop;

   // The RX byte is consumed on the same edge that captures it into io_rdata_q.
   assign bus.rx_ready = !rst_in && w_io_rd && (w_reg == IO_REG_IN) && bus.rx_valid;

   // Block-RAM style: write port plus read-enabled output register.
   always_ff @(posedge clk_in) begin
      if (w_ram_wr) ram_q[w_ram_addr] <= bus.mem_dout;
      if (w_ram_rd) ram_rdata_q       <= ram_q[w_ram_addr];
   end

   always_comb begin
      io_rdata_d = io_rdata_q;
      src_ram_d  = src_ram_q;
      snap_d     = snap_q;
      if (!bus.mem_wr) begin
         src_ram_d = !w_io;
         if (w_io) begin
            case (w_reg)
               IO_REG_IN:   io_rdata_d = bus.rx_valid ? bus.rx_data : '0;
               IO_REG_CLK0: begin
                  io_rdata_d = cnt_q[7:0];
                  snap_d     = cnt_q;
               end
               IO_REG_CLK1: io_rdata_d = snap_q[15:8];
               IO_REG_CLK2: io_rdata_d = snap_q[23:16];
               IO_REG_CLK3: io_rdata_d = snap_q[31:24];
               default:     io_rdata_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         io_rdata_q     <= '0;
         src_ram_q      <= 1'b0;
         snap_q         <= '0;
         cnt_q          <= '0;
         program_stop_q <= 1'b0;
         tx_overflow_q  <= 1'b0;
      end else begin
         io_rdata_q <= io_rdata_d;
         src_ram_q  <= src_ram_d;
         snap_q     <= snap_d;
         cnt_q      <= cnt_q + 32'd1;
         if (w_io_wr && w_reg == IO_REG_CLK0) program_stop_q <= 1'b1;
         if (w_overflow)                      tx_overflow_q  <= 1'b1;
      end
   end

   mem_io_responder_sync_fifo #(
      .WIDTH (BYTE_W),
      .DEPTH (TX_FIFO_DEPTH)
   ) u_tx_fifo (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .push_i        (w_tx_push),
      .din_i         (w_tx_din),
      .pop_i         (w_tx_pop),
      .dout_o        (bus.tx_data),
      .full_o        (w_tx_full),
      .empty_o       (w_tx_empty),
      .count_o       (w_unused_tx_count),
      .almost_full_o (bus.io_buffer_full)
   );

   assign bus.mem_din      = src_ram_q ? ram_rdata_q : io_rdata_q;
   assign bus.tx_valid     = !w_tx_empty;
   assign bus.program_stop = program_stop_q;
   assign bus.tx_overflow  = tx_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_io_responder
// Description : Directed self-checking bench for mem_io_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_io_responder;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [7:0] b0, b1, b2, b3;

   mem_io_responder_if bus ();

   mem_io_responder #(
      .RAM_ADDR_WIDTH (17),
      .TX_FIFO_DEPTH  (16)
   ) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one request at the falling edge; it is sampled on the next rise.
   task automatic cyc(input logic [31:0] a, input logic [7:0] d, input logic wr);
      @(negedge clk);
      bus.mem_a    = a;
      bus.mem_dout = d;
      bus.mem_wr   = wr;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] c_IDLE = 32'h0003_0008;

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.mem_a     = c_IDLE;
      bus.mem_dout  = 8'h00;
      bus.mem_wr    = 1'b0;
      bus.tx_ready  = 1'b0;
      bus.rx_data   = 8'h00;
      bus.rx_valid  = 1'b0;

      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_din",   32'(bus.mem_din), 32'h00);
      check("rst_tx_valid",  32'(bus.tx_valid), 32'h0);
      check("rst_tx_data",   32'(bus.tx_data), 32'h00);
      check("rst_iobuf",     32'(bus.io_buffer_full), 32'h0);
      check("rst_stop",      32'(bus.program_stop), 32'h0);
      check("rst_ovf",       32'(bus.tx_overflow), 32'h0);
      check("rst_rx_ready",  32'(bus.rx_ready), 32'h0);

      // ---------------- cycle counter snapshot ----------------
      // Reset drops at N0; the read at N99 sees 99 counted edges.
      @(negedge clk);
      rst = 1'b0;
      repeat (98) @(negedge clk);
      cyc(32'h0003_0004, 8'h00, 1'b0); tick; b0 = bus.mem_din;
      check("clk_byte0", 32'(b0), 32'd99);
      cyc(32'h0003_0005, 8'h00, 1'b0); tick; b1 = bus.mem_din;
      check("clk_byte1", 32'(b1), 32'd0);
      cyc(32'h0003_0006, 8'h00, 1'b0); tick; b2 = bus.mem_din;
      cyc(32'h0003_0007, 8'h00, 1'b0); tick; b3 = bus.mem_din;
      check("clk_word", {b3, b2, b1, b0}, 32'd99);
      cyc(32'h0003_0004, 8'h00, 1'b0); tick;
      check("clk_live", 32'(bus.mem_din), 32'd103);

      // ---------------- RAM ----------------
      cyc(32'h0001_FFFF, 8'h3C, 1'b1);
      cyc(32'h0001_FFFF, 8'h00, 1'b0); tick;
      check("ram_top", 32'(bus.mem_din), 32'h3C);
      cyc(32'h0000_0010, 8'hA5, 1'b1); tick;
      check("ram_wr_hold", 32'(bus.mem_din), 32'h3C);
      cyc(32'h0000_0010, 8'h00, 1'b0); tick;
      check("ram_raw", 32'(bus.mem_din), 32'hA5);
      cyc(32'h0001_FFFF, 8'h00, 1'b0);
      cyc(32'hFFFC_0010, 8'h00, 1'b0); tick;
      check("ram_hi_ignored", 32'(bus.mem_din), 32'hA5);

      // ---------------- UART RX ----------------
      cyc(32'h0003_0000, 8'h00, 1'b0);
      bus.rx_valid = 1'b1; bus.rx_data = 8'h7E;
      #1; check("rx_ready_pulse", 32'(bus.rx_ready), 32'h1);
      tick; check("rx_data", 32'(bus.mem_din), 32'h7E);
      cyc(32'h0003_0000, 8'h00, 1'b0);
      bus.rx_valid = 1'b0; bus.rx_data = 8'h55;
      #1; check("rx_ready_idle", 32'(bus.rx_ready), 32'h0);
      tick; check("rx_empty_data", 32'(bus.mem_din), 32'h00);
      cyc(c_IDLE, 8'h00, 1'b0);
      bus.rx_valid = 1'b1;
      #1; check("rx_ready_other_addr", 32'(bus.rx_ready), 32'h0);
      tick; bus.rx_valid = 1'b0;
      check("io_other_read", 32'(bus.mem_din), 32'h00);

      // ---------------- TX streaming, zero byte skipped ----------------
      cyc(32'h0003_0000, 8'h41, 1'b1); bus.tx_ready = 1'b1; tick;
      check("tx_first_valid", 32'(bus.tx_valid), 32'h1);
      check("tx_first_data",  32'(bus.tx_data),  32'h41);
      cyc(32'h0003_0000, 8'h00, 1'b1); tick;
      check("tx_zero_skipped", 32'(bus.tx_valid), 32'h0);
      cyc(32'h0003_0000, 8'h42, 1'b1); tick;
      check("tx_second_data", 32'(bus.tx_data), 32'h42);
      cyc(c_IDLE, 8'h00, 1'b0); tick;
      check("tx_drained", 32'(bus.tx_valid), 32'h0);

      // ---------------- TX fill, almost-full, overflow ----------------
      bus.tx_ready = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         cyc(32'h0003_0000, 8'(i), 1'b1); tick;
         if (i == 13) check("iobuf_at_13", 32'(bus.io_buffer_full), 32'h0);
         if (i == 14) check("iobuf_at_14", 32'(bus.io_buffer_full), 32'h1);
      end
      check("ovf_before", 32'(bus.tx_overflow), 32'h0);
      cyc(32'h0003_0000, 8'h99, 1'b1); tick;
      check("ovf_after", 32'(bus.tx_overflow), 32'h1);
      for (int i = 1; i <= 16; i++) begin
         check($sformatf("drain_%0d", i), 32'(bus.tx_data), 32'(i));
         cyc(c_IDLE, 8'h00, 1'b0); bus.tx_ready = 1'b1; tick;
      end
      check("drain_empty", 32'(bus.tx_valid), 32'h0);
      check("drain_iobuf", 32'(bus.io_buffer_full), 32'h0);
      bus.tx_ready = 1'b0;

      // ---------------- program stop, then reset mid-stream ----------------
      cyc(32'h0003_0004, 8'h55, 1'b1); tick;
      check("stop_flag",    32'(bus.program_stop), 32'h1);
      check("stop_tx_valid", 32'(bus.tx_valid), 32'h1);
      check("stop_tx_zero", 32'(bus.tx_data), 32'h00);
      cyc(32'h0003_0000, 8'h11, 1'b1);
      cyc(32'h0003_0000, 8'h22, 1'b1);
      cyc(32'h0000_0010, 8'h00, 1'b0); tick;
      check("pre_rst_read", 32'(bus.mem_din), 32'hA5);
      cyc(32'h0001_FFFF, 8'h00, 1'b0); rst = 1'b1; tick;
      check("mid_rst_mem_din", 32'(bus.mem_din), 32'h00);
      check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'h0);
      check("mid_rst_tx_data", 32'(bus.tx_data), 32'h00);
      check("mid_rst_stop", 32'(bus.program_stop), 32'h0);
      check("mid_rst_ovf", 32'(bus.tx_overflow), 32'h0);
      cyc(32'h0003_0004, 8'h00, 1'b0); rst = 1'b0; tick;
      check("cnt_restart_0", 32'(bus.mem_din), 32'd0);
      cyc(32'h0003_0004, 8'h00, 1'b0); tick;
      check("cnt_restart_1", 32'(bus.mem_din), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
Target-side counterpart of the CPU's byte-wide memory bus. It answers the CPU's requests on mem_a, mem_dout and mem_wr and returns data on mem_din. It holds the 128 KB program/data RAM and the memory-mapped I/O window (mem_a[17:16]==2'b11). The I/O window covers UART RX byte input, UART TX byte output through a TX FIFO, a free-running cycle counter and the program-stop flag. It drives io_buffer_full back to the CPU.

Parameters:
RAM_ADDR_WIDTH, 17, byte-address width of internal RAM (2^17 bytes)
TX_FIFO_DEPTH, 16, TX FIFO entries; power of two, >= 4

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
mem_a  input  32  CPU byte address; only [17:0] decoded
mem_dout  input  8  CPU write data
mem_wr  input  1  1 = write, 0 = read
mem_din  output  8  read data to CPU, valid one cycle after request
io_buffer_full  output  1  TX FIFO nearly full
tx_data  output  8  byte to UART transmitter
tx_valid  output  1  TX FIFO non-empty
tx_ready  input  1  UART transmitter accepts byte
rx_data  input  8  byte from UART receiver
rx_valid  input  1  RX byte available
rx_ready  output  1  one-cycle pop pulse to UART receiver
program_stop  output  1  sticky, set by write to 0x30004
tx_overflow  output  1  sticky, set when a TX push finds the FIFO full

Behaviour:
- Single clock domain.
- Reset values: mem_din=0, rx_ready=0, program_stop=0, tx_overflow=0, cycle counter=0, snapshot=0, FIFO empty (tx_valid=0, tx_data=0, io_buffer_full=0). RAM contents are not reset.
- Decode: io = (mem_a[17:16]==2'b11); otherwise RAM at mem_a[RAM_ADDR_WIDTH-1:0]. Bits [31:18] are ignored.
- RAM write (mem_wr=1, !io): ram[addr] <= mem_dout at the edge. No read data is produced that cycle; mem_din holds its previous value.
- RAM read (mem_wr=0, !io): mem_din <= ram[addr]; the CPU samples it in cycle N+1 for a request in cycle N. A read issued the cycle after a write to the same address returns the new byte.
- Cycle counter: 32-bit, +1 every cycle out of reset, wraps 0xFFFFFFFF -> 0.
- IO read 0x30000:
  - If rx_valid: mem_din <= rx_data and rx_ready=1 for that cycle.
  - Else: mem_din <= 0x00 and rx_ready=0.
  - Every read cycle at 0x30000 is a pop. The CPU never parks a read on 0x30000.
- IO read 0x30004: mem_din <= counter[7:0]; snapshot <= counter.
- IO read 0x30005/6/7: mem_din <= snapshot[15:8]/[23:16]/[31:24]. This gives a coherent 4-byte read when byte 0 is read first.
- IO write 0x30000: mem_dout != 0 pushes to TX FIFO; mem_dout == 0 is ignored.
- IO write 0x30004: program_stop <= 1 (sticky until reset) and 0x00 is pushed to TX FIFO.
- Other IO addresses: read returns 0x00; write is ignored.
- TX FIFO:
  - tx_valid = !empty; tx_data = head entry.
  - Pop when tx_valid & tx_ready.
  - Push when not full, or when full with a same-cycle pop (both take effect). Push + pop on empty: push only.
  - Push while full without a pop: byte dropped, tx_overflow <= 1 (sticky).
  - Pointers wrap modulo TX_FIFO_DEPTH; count occupies log2(depth)+1 bits.
- io_buffer_full = (count >= TX_FIFO_DEPTH-2), registered from next-state count. The two-entry margin covers the CPU's one-cycle reaction delay.
- Reset asserted mid-transaction: the pending read is discarded (mem_din=0), the FIFO is flushed and the counter is cleared on the same edge.

Decomposition:
- Shared package constants: IO_SEL (2'b11), IO_IN_ADDR (18'h30000), IO_CLK_ADDR (18'h30004), byte/address widths. These are already referenced by the CPU-side `config.v` macros; add them there.
- Sub-module sync_fifo (width 8, depth TX_FIFO_DEPTH, push/pop/full/empty/count) for the TX path. The RAM stays an inferred array in the top.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 next cycle -> mem_din=0xA5 in the following cycle; read 0x1FFFF after writing 0x3C there -> 0x3C.
- Write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx_data shows 0x41 then 0x42 only; 0x00 is never pushed.
- Hold tx_ready=0 and write 16 nonzero bytes -> io_buffer_full=1 once count reaches 14; 17th write drops, tx_overflow=1; FIFO order is preserved on drain.
- Reads at 0x30004..0x30007 starting 100 cycles after reset release -> the bytes reassemble to a single value (≈100) even though the counter advances between byte reads.
- rx_valid=1, rx_data=0x7E, read 0x30000 -> mem_din=0x7E and a one-cycle rx_ready pulse; with rx_valid=0 -> mem_din=0x00 and no pulse.
- Write to 0x30004 -> program_stop=1 and 0x00 appears on tx_data. Assert rst_in with 3 bytes queued -> next cycle tx_valid=0, program_stop=0, counter restarts at 0.
